// File: rtl/tinyvga_tx.sv
// rtl/tinyvga_tx.sv - VGA timing engine packing sync and 2-bit RGB onto the TinyVGA PMOD byte
// Counters drive pix_req; sync/active bits are delayed PIX_LAT clocks to meet the pixel, then registered.
module tinyvga_tx #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int PIX_LAT          = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] pix_rgb,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       pix_req,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic [7:0] pmod_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic       SYNC_ON   = (SYNC_ACTIVE_HIGH != 0);
  localparam logic       SYNC_OFF  = ~SYNC_ON;
  localparam logic [7:0] PMOD_IDLE = {SYNC_OFF, 3'b000, SYNC_OFF, 3'b000};

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] fc_q, fc_d;
  logic [7:0] pmod_q, pmod_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    if (enable) begin
      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d  = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fc_q <= fc_d;
    end
  end

  logic       hs_raw, vs_raw, act_raw;
  logic [2:0] raw;
  logic [2:0] dly;

  assign pix_req = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw  = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw  = (v_q >= VS_BEG) && (v_q < VS_END);
  assign act_raw = pix_req;
  assign raw     = {hs_raw, vs_raw, act_raw};

  // Delay line lines the timing bits up with a pixel that arrives PIX_LAT clocks late.
  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      logic [2:0] sr_q [PIX_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIX_LAT; i++) sr_q[i] <= 3'b000;
        end else if (enable) begin
          sr_q[0] <= raw;
          for (int i = 1; i < PIX_LAT; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign dly = sr_q[PIX_LAT-1];
    end
  endgenerate

  logic [5:0] colour;

  always_comb begin
    colour = dly[0] ? pix_rgb : 6'd0;
    pmod_d = {dly[2] ? SYNC_ON : SYNC_OFF, colour[0], colour[2], colour[4],
              dly[1] ? SYNC_ON : SYNC_OFF, colour[1], colour[3], colour[5]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmod_q <= PMOD_IDLE;
    end else if (enable) begin
      pmod_q <= pmod_d;
    end
  end

  assign hpos        = h_q;
  assign vpos        = v_q;
  assign frame_cnt   = fc_q;
  assign pmod_out    = pmod_q;
  assign line_start  = enable && (h_q == 10'd0);
  assign frame_start = line_start && (v_q == 10'd0);

endmodule
